reg_file_mp: RTL and testbench

Parametrised multi-port register file with per-byte write strobes, a configurable number of read and write ports, optional hardwired-zero register 0, optional same-cycle write-to-read bypass and a per-register busy scoreboard. It is the general-purpose operand store for datapath cores: several consumers read it, several producers write it, and issue logic uses the busy bits to stall on outstanding results.

---
 rtl/reg_file_mp.sv | 111 +++++++++++
 tb/tb_reg_file_mp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: byte-strobed writes, combinational reads, optional
// hardwired-zero r0, optional same-cycle write forwarding and a busy scoreboard.
module reg_file_mp #(
    parameter int DataWidth     = 32,
    parameter int NumRegs       = 8,
    parameter int IndexWidth    = $clog2(NumRegs),
    parameter int NumReadPorts  = 2,
    parameter int NumWritePorts = 2,
    parameter int ZeroReg       = 1,
    parameter int Bypass        = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NumWritePorts-1:0]              writeEn,
    input  logic [NumWritePorts*IndexWidth-1:0]   writeAddr,
    input  logic [NumWritePorts*DataWidth-1:0]    writeData,
    input  logic [NumWritePorts*DataWidth/8-1:0]  writeStrb,
    input  logic                                  reserveEn,
    input  logic [IndexWidth-1:0]                 reserveAddr,
    input  logic [NumReadPorts*IndexWidth-1:0]    readAddr,
    output logic [NumReadPorts*DataWidth-1:0]     readData,
    output logic [NumReadPorts-1:0]               readBusy
);

    localparam int NumBytes  = DataWidth / 8;
    localparam int AddrSpace = 2 ** IndexWidth;

    logic [DataWidth-1:0]  regs      [NumRegs];
    logic [DataWidth-1:0]  next_regs [NumRegs];
    logic [NumRegs-1:0]    busy;
    logic [NumRegs-1:0]    next_busy;
    logic [NumRegs-1:0]    write_hit;
    logic [NumRegs-1:0]    reserve_hit;
    logic [AddrSpace-1:0]  addr_ok;
    logic [IndexWidth-1:0] rd_addr   [NumReadPorts];

    // Addresses that map to real, writable storage (excludes r0 when hardwired).
    always_comb begin
        addr_ok = '0;
        for (int unsigned a = 0; a < AddrSpace; a++) begin
            addr_ok[a] = (a < NumRegs) && !((ZeroReg != 0) && (a == 0));
        end
    end

    // Later ports overwrite earlier ones byte by byte, so the highest-index
    // port with a given strobe set owns that byte.
    always_comb begin
        for (int unsigned r = 0; r < NumRegs; r++) begin
            next_regs[r]   = regs[r];
            write_hit[r]   = 1'b0;
            reserve_hit[r] = reserveEn && (reserveAddr == IndexWidth'(r)) && addr_ok[r];
            for (int unsigned p = 0; p < NumWritePorts; p++) begin
                if (writeEn[p] && (writeAddr[p*IndexWidth +: IndexWidth] == IndexWidth'(r))
                    && addr_ok[r]) begin
                    write_hit[r] = 1'b1;
                    for (int unsigned b = 0; b < NumBytes; b++) begin
                        if (writeStrb[p*NumBytes + b]) begin
                            next_regs[r][b*8 +: 8] = writeData[p*DataWidth + b*8 +: 8];
                        end
                    end
                end
            end
            if (reserve_hit[r]) begin
                next_busy[r] = 1'b1;
            end else if (write_hit[r]) begin
                next_busy[r] = 1'b0;
            end else begin
                next_busy[r] = busy[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NumRegs; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int unsigned r = 0; r < NumRegs; r++) begin
                regs[r] <= next_regs[r];
            end
            busy <= next_busy;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NumReadPorts; i++) begin
            rd_addr[i] = readAddr[i*IndexWidth +: IndexWidth];
        end
    end

    // Reads are gated by reset so forwarded write data cannot leak while held.
    always_comb begin
        readData = '0;
        readBusy = '0;
        for (int unsigned i = 0; i < NumReadPorts; i++) begin
            if (rst && addr_ok[rd_addr[i]]) begin
                if (Bypass != 0) begin
                    readData[i*DataWidth +: DataWidth] = next_regs[rd_addr[i]];
                    readBusy[i] = (write_hit[rd_addr[i]] && !reserve_hit[rd_addr[i]])
                                  ? 1'b0 : busy[rd_addr[i]];
                end else begin
                    readData[i*DataWidth +: DataWidth] = regs[rd_addr[i]];
                    readBusy[i] = busy[rd_addr[i]];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default instance (bypass, zero reg) and a
// 6-register instance without bypass or zero reg, driven by shared inputs.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  we;
    logic [5:0]  wa;
    logic [63:0] wd;
    logic [7:0]  ws;
    logic        re;
    logic [2:0]  ra;
    logic [5:0]  rda;
    logic [63:0] rd0, rd1;
    logic [1:0]  rb0, rb1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_mp dut0 (
        .clk(clk), .rst(rst), .writeEn(we), .writeAddr(wa), .writeData(wd),
        .writeStrb(ws), .reserveEn(re), .reserveAddr(ra), .readAddr(rda),
        .readData(rd0), .readBusy(rb0)
    );

    reg_file_mp #(.NumRegs(6), .ZeroReg(0), .Bypass(0)) dut1 (
        .clk(clk), .rst(rst), .writeEn(we), .writeAddr(wa), .writeData(wd),
        .writeStrb(ws), .reserveEn(re), .reserveAddr(ra), .readAddr(rda),
        .readData(rd1), .readBusy(rb1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        we = '0; wa = '0; wd = '0; ws = '0; re = 1'b0; ra = '0; rda = '0;
    endtask

    task automatic wr(input int p, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        we[p]        = 1'b1;
        wa[p*3 +: 3]  = a;
        wd[p*32 +: 32] = d;
        ws[p*4 +: 4]  = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        rda = {3'd3, 3'd3};
        repeat (2) tick();
        check("rst_rd_p0", rd0[31:0], 32'h0);
        check("rst_busy", {30'd0, rb0}, 32'h0);
        @(negedge clk) rst = 1'b1;
        tick();

        // reset asserted mid-cycle during a write
        wr(0, 3'd3, 32'hDEADBEEF, 4'hF);
        rda = {3'd3, 3'd3};
        #1;
        check("byp_r3", rd0[31:0], 32'hDEADBEEF);
        check("nobyp_r3", rd1[31:0], 32'h0);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_rd0", rd0[31:0], 32'h0);
        check("rst_mid_rd1", rd0[63:32], 32'h0);
        check("rst_mid_busy", {28'd0, rb0, rb1}, 32'h0);
        tick();
        clear_in();
        @(negedge clk) rst = 1'b1;
        rda = {3'd3, 3'd3};
        tick();
        check("r3_lost_d0", rd0[31:0], 32'h0);
        check("r3_lost_d1", rd1[63:32], 32'h0);

        // byte strobes
        wr(0, 3'd2, 32'h11223344, 4'hF);
        tick();
        clear_in();
        wr(0, 3'd2, 32'hAABBCCDD, 4'b0101);
        rda = {3'd0, 3'd2};
        #1;
        check("strb_byp", rd0[31:0], 32'h11BB33DD);
        check("strb_old", rd1[31:0], 32'h11223344);
        tick();
        clear_in();
        wr(1, 3'd2, 32'hFFFFFFFF, 4'h0);
        rda = {3'd2, 3'd2};
        #1;
        check("strb0_byp", rd0[63:32], 32'h11BB33DD);
        tick();
        check("strb_d0", rd0[31:0], 32'h11BB33DD);
        check("strb_d1", rd1[63:32], 32'h11BB33DD);

        // write conflict
        clear_in();
        wr(0, 3'd5, 32'h0000FFFF, 4'hF);
        wr(1, 3'd5, 32'h12345678, 4'b1100);
        rda = {3'd0, 3'd5};
        #1;
        check("conf_byp", rd0[31:0], 32'h1234FFFF);
        tick();
        check("conf_d1", rd1[31:0], 32'h1234FFFF);
        clear_in();
        wr(0, 3'd5, 32'hAAAAAAAA, 4'b0011);
        wr(1, 3'd5, 32'hBBBBBBBB, 4'b0110);
        rda = {3'd5, 3'd5};
        tick();
        check("conf2_d0", rd0[63:32], 32'h12BBBBAA);
        check("conf2_d1", rd1[31:0], 32'h12BBBBAA);

        // bypass vs stored
        clear_in();
        wr(1, 3'd4, 32'h00000A0A, 4'hF);
        rda = {3'd0, 3'd4};
        #1;
        check("byp_r4", rd0[31:0], 32'h00000A0A);
        check("nobyp_r4", rd1[31:0], 32'h0);
        tick();
        check("r4_after", rd1[31:0], 32'h00000A0A);

        // scoreboard
        clear_in();
        re = 1'b1; ra = 3'd1;
        rda = {3'd1, 3'd1};
        #1;
        check("rsv_lat", {31'd0, rb0[0]}, 32'h0);
        tick();
        clear_in();
        rda = {3'd1, 3'd1};
        #1;
        check("rsv_busy0", {30'd0, rb0}, 32'h3);
        check("rsv_busy1", {30'd0, rb1}, 32'h3);
        wr(0, 3'd1, 32'h00000505, 4'hF);
        #1;
        check("wr_clr_byp", {31'd0, rb0[0]}, 32'h0);
        check("wr_clr_nobyp", {31'd0, rb1[0]}, 32'h1);
        tick();
        clear_in();
        rda = {3'd1, 3'd1};
        #1;
        check("clr_busy", {28'd0, rb0, rb1}, 32'h0);
        check("r1_data", rd1[31:0], 32'h00000505);
        re = 1'b1; ra = 3'd4;
        tick();
        clear_in();
        wr(0, 3'd4, 32'h0, 4'h0);
        tick();
        clear_in();
        rda = {3'd4, 3'd4};
        #1;
        check("strb0_clr", {28'd0, rb0, rb1}, 32'h0);
        check("strb0_keep", rd1[31:0], 32'h00000A0A);
        re = 1'b1; ra = 3'd6;
        wr(0, 3'd6, 32'h00006666, 4'hF);
        rda = {3'd6, 3'd6};
        #1;
        check("rsvwr_byp_d", rd0[31:0], 32'h00006666);
        check("rsvwr_byp_b", {31'd0, rb0[0]}, 32'h0);
        tick();
        clear_in();
        rda = {3'd6, 3'd6};
        #1;
        check("rsvwr_busy", {31'd0, rb0[1]}, 32'h1);
        check("rsvwr_data", rd0[63:32], 32'h00006666);
        check("oor_data", rd1[31:0], 32'h0);
        check("oor_busy", {30'd0, rb1}, 32'h0);

        // zero register
        wr(0, 3'd0, 32'hFFFFFFFF, 4'hF);
        re = 1'b1; ra = 3'd0;
        rda = {3'd0, 3'd0};
        #1;
        check("zero_byp", rd0[31:0], 32'h0);
        tick();
        clear_in();
        rda = {3'd0, 3'd0};
        #1;
        check("zero_data", rd0[63:32], 32'h0);
        check("zero_busy", {30'd0, rb0}, 32'h0);
        check("r0_data_nz", rd1[31:0], 32'hFFFFFFFF);
        check("r0_busy_nz", {31'd0, rb1[0]}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
